// File: rtl/banner_pkg.sv
// ----------------------------------------------------------------------------
// banner_pkg
//
// Shared constants, FSM state type and a small helper for the banner scroller.
//
//   WORD_W  : banner ROM word width, one bit per banner column
//   ROWS    : ROM rows walked per frame (row index fits in ROW_W bits)
//   WIN_W   : visible window columns per presented row
//   ADDR_W  : banner ROM address width
//   ROW_W   : width of the row index presented to the LED row driver
//   OFS_W   : width of the scroll offset (covers 0..WORD_W-1)
//   state_t : sequencing FSM states
// ----------------------------------------------------------------------------
package banner_pkg;

    localparam int WORD_W = 70;
    localparam int ROWS   = 15;
    localparam int WIN_W  = 16;
    localparam int ADDR_W = 5;
    localparam int ROW_W  = 4;
    localparam int OFS_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_PRESENT = 3'd4,
        S_FRAME   = 3'd5
    } state_t;

    // Advance the scroll offset by one column, wrapping after the last
    // banner column back to column 0.
    function automatic logic [OFS_W-1:0] offset_step(
        input logic [OFS_W-1:0] ofs,
        input int               word_w
    );
        return (int'(ofs) == word_w - 1) ? '0 : ofs + 1'b1;
    endfunction

endpackage

// File: rtl/banner_window_extract.sv
// ----------------------------------------------------------------------------
// banner_window_extract
//
// Purely combinational window select. Picks WIN_W consecutive banner columns
// out of one ROM word, starting at i_offset and wrapping from the last column
// back to column 0.
//
// Column c of the banner is i_word[WORD_W-1-c] (column 0 is the MSB).
// Output bit o_window[WIN_W-1-k] carries column (i_offset + k) mod WORD_W,
// so o_window[WIN_W-1] is the leftmost visible column.
//
// Ports:
//   i_word   in  WORD_W  ROM word for the current row
//   i_offset in  OFS_W   scroll offset, 0..WORD_W-1
//   o_window out WIN_W   selected window bits
// ----------------------------------------------------------------------------
module banner_window_extract #(
    parameter int WORD_W = banner_pkg::WORD_W,
    parameter int WIN_W  = banner_pkg::WIN_W,
    parameter int OFS_W  = banner_pkg::OFS_W
) (
    input  logic [WORD_W-1:0] i_word,
    input  logic [OFS_W-1:0]  i_offset,
    output logic [WIN_W-1:0]  o_window
);

    // Column-ordered view of the word: w_cols[c] is banner column c.
    logic [WORD_W-1:0] w_cols;

    for (genvar c = 0; c < WORD_W; c++) begin : g_rev
        assign w_cols[c] = i_word[WORD_W-1-c];
    end

    // Offset is below WORD_W and k is below WIN_W <= WORD_W, so the sum is
    // below 2*WORD_W and a single compare/subtract replaces the modulo.
    for (genvar k = 0; k < WIN_W; k++) begin : g_win
        logic [OFS_W:0]   w_sum;
        logic [OFS_W-1:0] w_col;

        assign w_sum = {1'b0, i_offset} + (OFS_W+1)'(k);
        assign w_col = (w_sum >= (OFS_W+1)'(WORD_W))
                     ? OFS_W'(w_sum - (OFS_W+1)'(WORD_W))
                     : OFS_W'(w_sum);

        assign o_window[WIN_W-1-k] = w_cols[w_col];
    end

endmodule

// File: rtl/banner_scroller.sv
// ----------------------------------------------------------------------------
// banner_scroller
//
// Walks the banner glyph ROM row by row each frame, cuts a WIN_W-column
// window out of every row at the current scroll offset and hands each row to
// the LED row driver. The offset advances at most once per frame, and only
// between frames, so a frame never shows two different offsets.
//
// Ports:
//   clk        in  1       system clock
//   rst_n      in  1       asynchronous active-low reset
//   enable     in  1       run scroller; looked at only between frames
//   rom_addr   out ADDR_W  address to banner ROM (held outside ADDR)
//   rom_data   in  WORD_W  ROM word, valid the cycle after rom_addr
//   row_valid  out 1       row_pixels/row_idx valid
//   row_ready  in  1       row driver accepts row
//   row_idx    out ROW_W   row number of presented row
//   row_pixels out WIN_W   window bits, [WIN_W-1] = leftmost column
//   offset     out OFS_W   current scroll offset, 0..WORD_W-1
//   frame_done out 1       one-cycle pulse after the last row is accepted
//   dbg_state  out 3       current FSM state (state_t encoding)
//
// Row handshake: a row transfers on a clock edge where row_valid and
// row_ready are both high. Once row_valid rises, row_valid, row_idx and
// row_pixels hold steady until that transfer; row_valid falls the cycle
// after it. row_ready is ignored while row_valid is low.
//
// Per-row timing: ADDR (rom_addr presented) -> WAIT (ROM registers the
// address) -> CAPTURE (window latched) -> PRESENT (row_valid high).
// rom_addr is loaded on entry to ADDR so the ROM sees it during ADDR.
// ----------------------------------------------------------------------------
module banner_scroller #(
    parameter int ROWS     = banner_pkg::ROWS,
    parameter int WORD_W   = banner_pkg::WORD_W,
    parameter int WIN_W    = banner_pkg::WIN_W,
    parameter int STEP_DIV = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic [banner_pkg::ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]             rom_data,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [banner_pkg::ROW_W-1:0]  row_idx,
    output logic [WIN_W-1:0]              row_pixels,
    output logic [banner_pkg::OFS_W-1:0]  offset,
    output logic                          frame_done,
    output logic [2:0]                    dbg_state
);

    import banner_pkg::state_t;
    import banner_pkg::S_IDLE;
    import banner_pkg::S_ADDR;
    import banner_pkg::S_WAIT;
    import banner_pkg::S_CAPTURE;
    import banner_pkg::S_PRESENT;
    import banner_pkg::S_FRAME;
    import banner_pkg::offset_step;

    localparam int ADDR_W = banner_pkg::ADDR_W;
    localparam int ROW_W  = banner_pkg::ROW_W;
    localparam int OFS_W  = banner_pkg::OFS_W;
    localparam int PS_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ROW_W-1:0]    r_row;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ADDR_W-1:0]   w_rom_addr_nxt;
    logic                r_row_valid;
    logic                w_row_valid_nxt;
    logic [ROW_W-1:0]    r_row_idx;
    logic [ROW_W-1:0]    w_row_idx_nxt;
    logic [WIN_W-1:0]    r_row_pixels;
    logic [WIN_W-1:0]    w_row_pixels_nxt;
    logic [OFS_W-1:0]    r_offset;
    logic [OFS_W-1:0]    w_offset_nxt;
    logic                r_frame_done;
    logic                w_frame_done_nxt;

    logic [PS_W-1:0]     r_prescaler;
    logic                r_step_pending;
    logic                w_ps_wrap;
    logic                w_step_clr;

    logic [WIN_W-1:0]    w_window;

    // ------------------------------------------------------------------
    // Window extraction from the ROM word at the current offset
    // ------------------------------------------------------------------
    banner_window_extract #(
        .WORD_W (WORD_W),
        .WIN_W  (WIN_W),
        .OFS_W  (OFS_W)
    ) u_extract (
        .i_word   (rom_data),
        .i_offset (r_offset),
        .o_window (w_window)
    );

    // ------------------------------------------------------------------
    // Scroll prescaler: counts only while enabled. A wrap always wins over
    // the FRAME clear, so a wrap landing on the FRAME cycle is not lost;
    // several wraps inside one frame collapse into a single pending step.
    // ------------------------------------------------------------------
    assign w_ps_wrap = enable && (r_prescaler == PS_W'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler    <= '0;
            r_step_pending <= 1'b0;
        end else begin
            if (enable) begin
                r_prescaler <= w_ps_wrap ? '0 : r_prescaler + 1'b1;
            end
            if (w_ps_wrap) begin
                r_step_pending <= 1'b1;
            end else if (w_step_clr) begin
                r_step_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_rom_addr   <= '0;
            r_row_valid  <= 1'b0;
            r_row_idx    <= '0;
            r_row_pixels <= '0;
            r_offset     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_rom_addr   <= w_rom_addr_nxt;
            r_row_valid  <= w_row_valid_nxt;
            r_row_idx    <= w_row_idx_nxt;
            r_row_pixels <= w_row_pixels_nxt;
            r_offset     <= w_offset_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM: next state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_rom_addr_nxt   = r_rom_addr;
        w_row_valid_nxt  = r_row_valid;
        w_row_idx_nxt    = r_row_idx;
        w_row_pixels_nxt = r_row_pixels;
        w_offset_nxt     = r_offset;
        w_frame_done_nxt = 1'b0;
        w_step_clr       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt    = S_ADDR;
                    w_row_nxt      = '0;
                    w_rom_addr_nxt = '0;
                end
            end

            S_ADDR: begin
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                w_state_nxt = S_CAPTURE;
            end

            S_CAPTURE: begin
                w_row_pixels_nxt = w_window;
                w_row_idx_nxt    = r_row;
                w_row_valid_nxt  = 1'b1;
                w_state_nxt      = S_PRESENT;
            end

            S_PRESENT: begin
                if (row_ready) begin
                    w_row_valid_nxt = 1'b0;
                    if (r_row == ROW_W'(ROWS - 1)) begin
                        w_state_nxt      = S_FRAME;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_row_nxt      = r_row + 1'b1;
                        w_rom_addr_nxt = ADDR_W'(r_row) + 1'b1;
                        w_state_nxt    = S_ADDR;
                    end
                end
            end

            S_FRAME: begin
                // Offset changes only here, between the last row of one
                // frame and the first row of the next.
                if (r_step_pending) begin
                    w_offset_nxt = offset_step(r_offset, WORD_W);
                    w_step_clr   = 1'b1;
                end
                if (enable) begin
                    w_state_nxt    = S_ADDR;
                    w_row_nxt      = '0;
                    w_rom_addr_nxt = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr   = r_rom_addr;
    assign row_valid  = r_row_valid;
    assign row_idx    = r_row_idx;
    assign row_pixels = r_row_pixels;
    assign offset     = r_offset;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_banner_scroller.sv
// ----------------------------------------------------------------------------
// tb_banner_scroller
//
// Directed bench for banner_scroller with a small scroll divider so the
// offset steps once per frame. A registered ROM model supplies banner rows;
// hand-computed windows cover the notable offsets, and a per-frame expected
// queue built from a reference window function covers every row.
// ----------------------------------------------------------------------------
module tb_banner_scroller;
  import banner_pkg::*;

  localparam int STEP = 4;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              row_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              row_valid;
  logic [ROW_W-1:0]  row_idx;
  logic [WIN_W-1:0]  row_pixels;
  logic [OFS_W-1:0]  offset;
  logic              frame_done;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  banner_scroller #(
    .ROWS     (ROWS),
    .WORD_W   (WORD_W),
    .WIN_W    (WIN_W),
    .STEP_DIV (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .row_pixels (row_pixels),
    .offset     (offset),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Registered-address ROM: data follows rom_addr by one clock.
  logic [WORD_W-1:0] rom [0:31];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc      = 0;
  int fd_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) fd_count <= fd_count + 1;
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [WIN_W-1:0] exp_q[$];
  logic [WIN_W-1:0] seen [0:ROWS-1];
  int n_checks    = 0;
  int n_pass      = 0;
  int last_fd_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference window: bit [WIN_W-1-k] is column (ofs+k) mod WORD_W.
  function automatic logic [WIN_W-1:0] model_win(input logic [WORD_W-1:0] w, input int ofs);
    logic [WIN_W-1:0] res;
    int col;
    res = '0;
    for (int k = 0; k < WIN_W; k++) begin
      col = (ofs + k) % WORD_W;
      res[WIN_W-1-k] = w[WORD_W-1-col];
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Driver: consume one whole frame (rows 0..ROWS-1), optionally stalling one
  // row for 10 cycles or dropping enable once a given row is presented.
  // Entered and left on a negedge; leaves one cycle after FRAME.
  // --------------------------------------------------------------------------
  task automatic run_frame(input int exp_ofs, input int stall_row, input int drop_row);
    int               waits;
    int               fd0;
    bit               ok;
    logic [WIN_W-1:0] exp_pix;
    logic [WIN_W-1:0] snap_pix;
    logic [ROW_W-1:0] snap_idx;
    logic [ADDR_W-1:0] snap_addr;
    fd0 = fd_count;
    for (int i = 0; i < ROWS; i++) exp_q.push_back(model_win(rom[i], exp_ofs));
    for (int r = 0; r < ROWS; r++) begin
      if (r == stall_row) row_ready = 1'b0;
      waits = 0;
      while (!row_valid && waits < 12) begin
        @(negedge clk);
        waits++;
      end
      if (!row_valid) begin
        check($sformatf("o%0d_r%0d_valid_timeout", exp_ofs, r), 32'(row_valid), 32'd1);
        exp_q.delete();
        row_ready = 1'b1;
        return;
      end
      if (r == 1) check("addr_to_valid_latency", waits, 3);
      exp_pix = exp_q.pop_front();
      check($sformatf("o%0d_r%0d_idx", exp_ofs, r), 32'(row_idx), r);
      check($sformatf("o%0d_r%0d_pix", exp_ofs, r), 32'(row_pixels), 32'(exp_pix));
      check($sformatf("o%0d_r%0d_ofs", exp_ofs, r), 32'(offset), exp_ofs);
      seen[r] = row_pixels;
      if (r == drop_row) enable = 1'b0;
      if (r == stall_row) begin
        snap_pix  = row_pixels;
        snap_idx  = row_idx;
        snap_addr = rom_addr;
        ok = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (row_valid !== 1'b1 || row_idx !== snap_idx ||
              row_pixels !== snap_pix || rom_addr !== snap_addr) ok = 1'b0;
        end
        check("stall_outputs_stable", 32'(ok), 32'd1);
        check("stall_no_next_addr", 32'(rom_addr), r);
        row_ready = 1'b1;
      end
      @(negedge clk);
      check($sformatf("o%0d_r%0d_valid_drop", exp_ofs, r), 32'(row_valid), 32'd0);
    end
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    if (stall_row < 0 && last_fd_cyc >= 0) check("frame_cycles", cyc - last_fd_cyc, 61);
    last_fd_cyc = cyc;
    @(negedge clk);
    check("frame_done_width", 32'(frame_done), 32'd0);
    check("frame_done_count", fd_count - fd0, 1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit ok;
    int waits;
    for (int i = 0; i < 32; i++)
      rom[i] = {4'(i), 2'b10, 64'hA5A5_0000_0000_5A5A ^ (64'(i) * 64'h0101_0101_0101_0101)};
    rom[0] = {16'hFC0F, 44'h123_4567_89AB, 10'h001};
    rom[6] = {16'hFF8F, 44'h0FE_DCBA_9876, 10'h155};

    rst_n     = 1'b0;
    enable    = 1'b0;
    row_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_row_idx", 32'(row_idx), 32'd0);
    check("rst_row_pixels", 32'(row_pixels), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    rst_n     = 1'b1;
    enable    = 1'b1;
    row_ready = 1'b1;

    // Frame 0 at offset 0
    run_frame(0, -1, -1);
    check("f0_row0_hand", 32'(seen[0]), 32'h0000_FC0F);
    check("f0_row6_hand", 32'(seen[6]), 32'h0000_FF8F);

    // Frame 1 at offset 1 with row 3 stalled for 10 cycles
    run_frame(1, 3, -1);
    check("f1_row0_hand", 32'(seen[0]), 32'h0000_F81E);

    // Frames 2..70: one step per frame, wrap 69 -> 0 at frame 70
    for (int f = 2; f <= 70; f++) begin
      run_frame(f % WORD_W, -1, -1);
      if (f == 60) check("ofs60_row0_wrap_hand", 32'(seen[0]), 32'h0000_007F);
      if (f == 70) check("ofs_wrap_row0_hand", 32'(seen[0]), 32'h0000_FC0F);
    end

    // Frame 71 at offset 1, enable dropped while row 7 is presented
    run_frame(1, -1, 7);
    check("drop_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("drop_offset_stepped", 32'(offset), 32'd2);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rom_addr !== 5'd14 || row_valid !== 1'b0 || dbg_state !== 3'(S_IDLE)) ok = 1'b0;
    end
    check("idle_quiet", 32'(ok), 32'd1);
    last_fd_cyc = -1;

    // Async reset while a row is being presented
    row_ready = 1'b0;
    enable    = 1'b1;
    waits = 0;
    while (!row_valid && waits < 12) begin
      @(negedge clk);
      waits++;
    end
    check("pre_reset_valid", 32'(row_valid), 32'd1);
    check("pre_reset_idx", 32'(row_idx), 32'd0);
    check("pre_reset_offset", 32'(offset), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(row_valid), 32'd0);
    check("async_rst_offset", 32'(offset), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n     = 1'b1;
    row_ready = 1'b1;
    run_frame(0, -1, -1);
    check("post_reset_row0_hand", 32'(seen[0]), 32'h0000_FC0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
